// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: per-source one-entry buffers, fixed priority
// with starvation aging, write-after-write squash and a pending-rd mask.
module rf_writeback_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      halt,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*REG_W-1:0]  req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      register_write_enable,
  output logic [REG_W-1:0]          destination_register,
  output logic [DATA_W-1:0]         value_to_write_to_reg,
  output logic [1:0]                grant_id,
  output logic [(1<<REG_W)-1:0]     pending_mask
);

  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned ID_W  = 2;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [NUM_REQ-1:0] full_q, full_d;
  logic [REG_W-1:0]   rd_q   [NUM_REQ];
  logic [REG_W-1:0]   rd_d   [NUM_REQ];
  logic [DATA_W-1:0]  data_q [NUM_REQ];
  logic [DATA_W-1:0]  data_d [NUM_REQ];
  logic [AGE_W-1:0]   age_q  [NUM_REQ];
  logic [AGE_W-1:0]   age_d  [NUM_REQ];

  logic               wen_q, wen_d;
  logic [REG_W-1:0]   wrd_q, wrd_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [ID_W-1:0]    gid_q, gid_d;

  logic [REG_W-1:0]   in_rd   [NUM_REQ];
  logic [DATA_W-1:0]  in_data [NUM_REQ];
  logic [NUM_REQ-1:0] starved, cand, grant, accept, keep, squash;
  logic               any_grant;
  logic [ID_W-1:0]    g_idx;
  logic [REG_W-1:0]   g_rd;
  logic [DATA_W-1:0]  g_data;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      in_rd[i]   = req_rd[i*REG_W +: REG_W];
      in_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Starved buffers take precedence; ties and the normal case go to the lowest index.
  always_comb begin
    starved   = '0;
    grant     = '0;
    any_grant = 1'b0;
    g_idx     = '0;
    g_rd      = '0;
    g_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = full_q[i] && (age_q[i] >= AGE_MAX);
    end
    cand = halt ? '0 : ((|starved) ? starved : full_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand[i] && !any_grant) begin
        grant[i]  = 1'b1;
        any_grant = 1'b1;
        g_idx     = ID_W'(i);
        g_rd      = rd_q[i];
        g_data    = data_q[i];
      end
    end
  end

  assign req_ready = {NUM_REQ{~halt}} & (~full_q | grant);

  // rd==0 is consumed without buffering; same-cycle duplicates keep the lowest index.
  always_comb begin
    accept = '0;
    keep   = '0;
    squash = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      accept[i] = req_valid[i] && req_ready[i] && (in_rd[i] != '0);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      keep[i] = accept[i];
      for (int j = 0; j < i; j++) begin
        if (accept[j] && (in_rd[j] == in_rd[i])) keep[i] = 1'b0;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((i != j) && keep[i] && full_q[j] && !grant[j] && (in_rd[i] == rd_q[j]))
          squash[j] = 1'b1;
      end
    end
  end

  always_comb begin
    full_d  = full_q;
    rd_d    = rd_q;
    data_d  = data_q;
    age_d   = age_q;
    wen_d   = any_grant;
    wrd_d   = wrd_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    if (any_grant) begin
      wrd_d   = g_rd;
      wdata_d = g_data;
      gid_d   = g_idx;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (keep[i]) begin
        full_d[i] = 1'b1;
        rd_d[i]   = in_rd[i];
        data_d[i] = in_data[i];
        age_d[i]  = '0;
      end else if (grant[i] || squash[i]) begin
        full_d[i] = 1'b0;
        age_d[i]  = '0;
      end else if (full_q[i] && any_grant && (age_q[i] < AGE_MAX)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q  <= '0;
      wen_q   <= 1'b0;
      wrd_q   <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      full_q  <= full_d;
      wen_q   <= wen_d;
      wrd_q   <= wrd_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (full_q[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  assign register_write_enable = wen_q;
  assign destination_register  = wrd_q;
  assign value_to_write_to_reg = wdata_q;
  assign grant_id              = gid_q;

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Shares the single register-file write port (register_write_enable / destination_register / value_to_write_to_reg) among NUM_REQ writeback sources: index 0 = MEM load, 1 = integer ALU, 2 = multi-cycle FP unit.
- Each source gets a one-entry holding buffer, a valid/ready handshake and a fixed-priority arbiter with starvation aging.
- Exports a pending-write mask to the hazard/forwarding logic.
- Sits between the execute/memory stages and the register-file write port.

Parameters:
- NUM_REQ, 3: number of writeback requesters. Index 0 has the highest base priority.
- DATA_W, 32: write data width.
- REG_W, 5: register index width.
- STARVE_LIMIT, 4: number of consecutive lost arbitrations after which a requester is promoted.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- halt  in  1  freezes all grants and acceptance.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester acceptance.
- req_rd  in  NUM_REQ*REG_W  destination register. Requester i occupies slice [i*REG_W +: REG_W].
- req_data  in  NUM_REQ*DATA_W  write data, sliced the same way.
- register_write_enable  out  1  registered RF write strobe.
- destination_register  out  REG_W  registered RF write index.
- value_to_write_to_reg  out  DATA_W  registered RF write data.
- grant_id  out  2  index of the requester driving the current write. Valid only when register_write_enable=1.
- pending_mask  out  32  bit r=1 while any holding buffer holds rd=r.

Behaviour:
- Reset (reset=0, asynchronous): all buffers empty, all aging counters 0, register_write_enable=0, destination_register=0, value_to_write_to_reg=0, grant_id=0, pending_mask=0. Reset asserted mid-operation discards buffered writes with no partial write.
- req_ready[i] = !halt & (buf_full[i]==0 | grant[i] this cycle). Combinational; a buffer freed this cycle accepts a new entry on the same edge.
- Acceptance: on req_valid[i]&req_ready[i] the rd and data are captured into buf[i].
- rd==0: the request is accepted but nothing is buffered and no write is issued.
- Arbitration: combinational, over full buffers each cycle, only when halt=0.
  - Any requester with age[i]>=STARVE_LIMIT wins; lowest index among those.
  - Otherwise the lowest-index full buffer wins.
- Grant effects at the edge:
  - The output registers load rd/data, register_write_enable=1 and grant_id=i.
  - buf[i] clears; age[i] clears.
  - Every other full buffer that lost increments its age, saturating at STARVE_LIMIT.
- With no grant, register_write_enable=0 after the edge; destination_register and value_to_write_to_reg hold their values.
- Latency: a request sampled at edge E0 and granted in the following cycle is on the write port after E1. One-cycle-latency write-back = 2 edges minimum.
- Throughput: one write per cycle.
- Write-after-write ordering (last accepted wins):
  - A newly accepted entry whose rd matches another full buffer not being granted this cycle squashes (clears) that older buffer. The squashed buffer's age also clears.
  - If the older entry is granted in the same cycle, the grant proceeds and the new entry is buffered, so it is written later.
  - Simultaneous same-rd acceptances: the lowest index is kept; the others are accepted and dropped.
- halt=1:
  - req_ready=0 and no grants.
  - register_write_enable=0 after the next edge.
  - Buffers, ages and pending_mask hold.
  - Release resumes arbitration in the first cycle after halt deasserts.
- pending_mask: combinational OR of decoded rd over full buffers. It excludes the entry currently on the output registers.

Test Plan:
- Single write: after reset release, req_valid[1]=1, rd=7, data=32'hDEADBEEF for one cycle → two edges later register_write_enable=1, destination_register=7, value=DEADBEEF, grant_id=1 for exactly one cycle.
- Priority plus aging, STARVE_LIMIT=4: req 0 valid every cycle with rd=1..n, req 2 holds rd=9 from the same cycle → req 0 wins 4 cycles, req 2 (rd=9) is written in the 5th grant cycle, then req 0 resumes.
- Write-after-write squash: req 2 buffers rd=5 data=AAAA0000, then req 0 holds the port with other writes, then req 1 sends rd=5 data=BBBB0000 → exactly one write to x5 with BBBB0000; AAAA0000 is never written.
- Same-cycle same-rd arrivals: req 0 and req 1 both send rd=3 (data 1 and 2) in the same cycle → a single write of 1 to x3; both req_ready=1 in that cycle.
- rd=0 plus halt: req 1 sends rd=0 → no write and pending_mask stays 0. Buffer rd=12 on req 2, assert halt for 3 cycles → no write, req_ready=0, pending_mask[12]=1 throughout; after release rd=12 is written the next cycle.
- Asynchronous reset mid-stream: with all three buffers full, drive reset=0 between clock edges → outputs and pending_mask go to 0 immediately; after reset release no stale writes appear.
